tdpram: RTL and testbench
=========================

TDPRAM -- requirements
Module: tdpram

Interface
REQ-001 The block SHALL expose parameter DATA, default 16, meaning word width in bits (multiple of 8).
REQ-002 The block SHALL expose parameter ADDR, default 5, meaning address width; depth = 2**ADDR.
REQ-003 The block SHALL expose parameter OUT_REG, default 0, meaning 1 adds an output pipeline register to both ports.
REQ-004 The block SHALL use NBE = DATA/8 byte lanes throughout.
REQ-005 The block SHALL provide clk  input  1  the single clock, all logic on its rising edge.
REQ-006 The block SHALL provide rst  input  1  reset, synchronous, active-high.
REQ-007 The block SHALL provide clr  input  1  single-cycle request to re-zero the whole memory.
REQ-008 The block SHALL provide busy  output  1  high while clear sequence runs.
REQ-009 The block SHALL provide ena / enb  input  1  port access enable.
REQ-010 The block SHALL provide wea / web  input  NBE  per-byte write enables, honoured only with en.
REQ-011 The block SHALL provide addra / addrb  input  ADDR  word address.
REQ-012 The block SHALL provide dina / dinb  input  DATA  write data.
REQ-013 The block SHALL provide douta / doutb  output  DATA  read data.
REQ-014 The block SHALL provide vlda / vldb  output  1  read data valid strobe.
REQ-015 The block SHALL provide col  output  1  cross-port address collision flag.

Function
REQ-016 The FSM SHALL have states CLEAR and READY; rst, or clr while in READY, enters CLEAR with the clear counter at 0.
REQ-017 In CLEAR, the FSM SHALL write all-zero to address cnt each cycle, increment cnt, and enter READY after writing address 2**ADDR-1, so a clear takes exactly 2**ADDR cycles.
REQ-018 busy SHALL equal 1 exactly when the state is CLEAR.
REQ-019 While busy, ena/enb SHALL be ignored: no writes, vld stays 0, col stays 0.
REQ-020 clr asserted while busy SHALL be ignored and SHALL NOT restart the counter.
REQ-021 Any port with en=1 in READY SHALL perform a read, and its vld SHALL pulse 1 + OUT_REG cycles later, aligned with dout.
REQ-022 Writes SHALL update byte lane i only where we[i]=1; other lanes SHALL keep their old content.
REQ-023 Reads SHALL be read-first: a same-cycle write to the same address, from either port, SHALL NOT be visible in that read's dout.
REQ-024 When both ports write the same address in the same cycle, port A SHALL win each byte lane both enable, and each port SHALL write its exclusive lanes.
REQ-025 col SHALL pulse for one cycle, one cycle after a READY cycle with ena=enb=1, addra==addrb and (|wea or |web).
REQ-026 dout SHALL hold its last value when no read occurs.
REQ-027 With OUT_REG=1, the pipeline register SHALL be unconditionally enabled and vld SHALL be delayed identically.

Reset
REQ-028 On rst, douta, doutb and the output pipeline registers SHALL go to 0, vlda=vldb=col=0, busy=1 on the next cycle, and state=CLEAR with cnt=0.
REQ-029 rst asserted mid-clear SHALL restart the clear from address 0.
REQ-030 rst SHALL have priority over clr and port activity in the same cycle.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding (CLEAR=0, READY=1) and the NBE derivation constant.
REQ-032 The clear FSM and counter SHALL be a sub-module, tdpram_clr_fsm (outputs: busy, clear-write enable, clear address).
REQ-033 Port A's write path SHALL be muxed with the clear write.
REQ-034 Memory SHALL be a single array of 2**ADDR x DATA with no other storage.

Verification (DATA=16, ADDR=5)
REQ-035 Bench SHALL drive rst for 1 cycle, then idle -> busy=1 for exactly 32 cycles, then 0; reads of addresses 0..31 return 0x0000.
REQ-036 Bench SHALL, in READY, write A addr 3 = 0xABCD with wea=2'b11, then write A addr 3 = 0x1200 with wea=2'b10, then read B addr 3 -> doutb=0x12CD, vldb 1 cycle after the read (OUT_REG=0) or 2 cycles after (OUT_REG=1).
REQ-037 Bench SHALL drive the same cycle with A writing addr 7 = 0x1111 (wea=2'b01) and B writing addr 7 = 0x2222 (web=2'b11) -> col pulses next cycle; a later read of addr 7 = 0x2211.
REQ-038 Bench SHALL, with addr 9 holding 0x5555, drive the same cycle with B writing 0x6666 to addr 9 and A reading addr 9 -> douta=0x5555; the next read of addr 9 = 0x6666.
REQ-039 Bench SHALL write addr 4 = 0xBEEF, then pulse clr; during busy, attempt an A write of addr 5 = 0x0001 and pulse clr again -> busy lasts exactly 32 cycles from the first clr, and reads of addr 4 and addr 5 return 0x0000.
REQ-040 Bench SHALL assert rst at clear cycle 10 -> busy stays high 32 cycles after the rst cycle, douta=doutb=0, vlda=vldb=0.

Source files
------------

// File: rtl/tdpram_pkg.sv
// tdpram_pkg: shared FSM encoding and byte-lane derivation for the true dual-port RAM
package tdpram_pkg;
  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] READY = 1'b1;
  localparam int BYTE_W = 8;
  function automatic int nbe(input int data);
    return data / BYTE_W;
  endfunction
endpackage

// File: rtl/tdpram_if.sv
// tdpram_if: one RAM access port (enable, byte enables, address, data, read strobe)
interface tdpram_if
  import tdpram_pkg::*;
#(
  parameter int DATA = 16,
  parameter int ADDR = 5
);
  logic en;
  logic [nbe(DATA)-1:0] we;
  logic [ADDR-1:0] addr;
  logic [DATA-1:0] din;
  logic [DATA-1:0] dout;
  logic vld;
  modport master(output en, we, addr, din, input dout, vld);
  modport slave(input en, we, addr, din, output dout, vld);
endinterface

// File: rtl/tdpram_clr_fsm.sv
// tdpram_clr_fsm: sweeps every address once after reset or a clear request
module tdpram_clr_fsm
  import tdpram_pkg::*;
#(
  parameter int ADDR = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic busy,
  output logic cwe,
  output logic [ADDR-1:0] caddr
);
  logic [0:0] state;
  logic [ADDR-1:0] cnt;
  // clr is only honoured in READY so a running sweep is never restarted by it
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt <= '0;
    end else if (state == CLEAR) begin
      cnt <= cnt + 1'b1;
      if (&cnt) state <= READY;
    end else if (clr) begin
      state <= CLEAR;
      cnt <= '0;
    end
  end
  assign busy = state == CLEAR;
  assign cwe = busy;
  assign caddr = cnt;
endmodule

// File: rtl/tdpram.sv
// tdpram: byte-writable true dual-port RAM with read-first ports and self-clear
module tdpram
  import tdpram_pkg::*;
#(
  parameter int DATA = 16,
  parameter int ADDR = 5,
  parameter int OUT_REG = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic busy,
  output logic col,
  tdpram_if.slave pa,
  tdpram_if.slave pb
);
  localparam int NBE = nbe(DATA);
  logic [DATA-1:0] mem [2**ADDR];
  logic cwe, act;
  logic [ADDR-1:0] caddr, wa_addr;
  logic [NBE-1:0] wa_be, wb_be;
  logic [DATA-1:0] wa_din, ra, rb, oa, ob;
  logic va, vb, ova, ovb;
  tdpram_clr_fsm #(.ADDR(ADDR)) u_fsm (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .busy(busy),
    .cwe(cwe),
    .caddr(caddr)
  );
  // port A's write path carries the clear sweep while busy; reset blocks all writes
  always_comb begin
    act = !rst && !busy;
    wa_be = (cwe && !rst) ? {NBE{1'b1}} : ((act && pa.en) ? pa.we : '0);
    wa_addr = cwe ? caddr : pa.addr;
    wa_din = cwe ? '0 : pa.din;
    wb_be = (act && pb.en) ? pb.we : '0;
  end
  // B is written first so A overrides shared lanes on a same-address collision
  always_ff @(posedge clk) begin
    for (int i = 0; i < NBE; i++) begin
      if (wb_be[i]) mem[pb.addr][8*i +: 8] <= pb.din[8*i +: 8];
      if (wa_be[i]) mem[wa_addr][8*i +: 8] <= wa_din[8*i +: 8];
    end
  end
  // read-first registered reads, valid strobes and collision flag
  always_ff @(posedge clk) begin
    if (rst) begin
      ra <= '0;
      rb <= '0;
      va <= 1'b0;
      vb <= 1'b0;
      col <= 1'b0;
    end else begin
      if (act && pa.en) ra <= mem[pa.addr];
      if (act && pb.en) rb <= mem[pb.addr];
      va <= act && pa.en;
      vb <= act && pb.en;
      col <= act && pa.en && pb.en && (pa.addr == pb.addr) && ((|pa.we) || (|pb.we));
    end
  end
  if (OUT_REG != 0) begin : g_oreg
    // free-running output stage, data and strobe delayed together
    always_ff @(posedge clk) begin
      if (rst) begin
        oa <= '0;
        ob <= '0;
        ova <= 1'b0;
        ovb <= 1'b0;
      end else begin
        oa <= ra;
        ob <= rb;
        ova <= va;
        ovb <= vb;
      end
    end
  end else begin : g_noreg
    assign oa = ra;
    assign ob = rb;
    assign ova = va;
    assign ovb = vb;
  end
  assign pa.dout = oa;
  assign pb.dout = ob;
  assign pa.vld = ova;
  assign pb.vld = ovb;
endmodule

// File: tb/tb_tdpram.sv
// tb_tdpram: directed checks of clear sequencing, byte writes, collisions and read-first
module tb_tdpram;
  localparam int OUT_REG = 0;
  logic clk = 1'b0;
  logic rst, clr, busy, col;
  int checks = 0;
  int errors = 0;
  tdpram_if #(.DATA(16), .ADDR(5)) a ();
  tdpram_if #(.DATA(16), .ADDR(5)) b ();
  tdpram #(.DATA(16), .ADDR(5), .OUT_REG(OUT_REG)) dut (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .busy(busy),
    .col(col),
    .pa(a),
    .pb(b)
  );
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a.en = 0; a.we = '0; a.addr = '0; a.din = '0;
    b.en = 0; b.we = '0; b.addr = '0; b.din = '0;
  endtask

  task automatic wr(input bit pb_sel, input logic [4:0] ad, input logic [1:0] we, input logic [15:0] d);
    if (pb_sel) begin b.en = 1; b.we = we; b.addr = ad; b.din = d; end
    else begin a.en = 1; a.we = we; a.addr = ad; a.din = d; end
    tick();
    idle();
  endtask

  task automatic rd(input bit pb_sel, input logic [4:0] ad, output logic [15:0] d, output logic v);
    if (pb_sel) begin b.en = 1; b.addr = ad; end
    else begin a.en = 1; a.addr = ad; end
    tick();
    idle();
    repeat (OUT_REG) tick();
    d = pb_sel ? b.dout : a.dout;
    v = pb_sel ? b.vld : a.vld;
  endtask

  task automatic test_reset();
    int n;
    logic [15:0] d;
    logic v;
    rst = 1;
    tick();
    rst = 0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %b want 1", busy); end
    checks++;
    if (a.dout !== 16'h0 || b.dout !== 16'h0 || a.vld !== 1'b0 || b.vld !== 1'b0 || col !== 1'b0) begin
      errors++;
      $display("FAIL reset_outs got douta=%h doutb=%h vlda=%b vldb=%b col=%b want zeros", a.dout, b.dout, a.vld, b.vld, col);
    end
    n = 0;
    while (busy && n < 100) begin n++; tick(); end
    checks++;
    if (n != 32) begin errors++; $display("FAIL reset_busy_len got %0d want 32", n); end
    for (int i = 0; i < 32; i++) begin
      rd(i[0], 5'(i), d, v);
      checks++;
      if (d !== 16'h0 || v !== 1'b1) begin errors++; $display("FAIL reset_zero[%0d] got %h vld=%b want 0000 vld=1", i, d, v); end
    end
  endtask

  task automatic test_byte_write();
    logic [15:0] d;
    logic v;
    wr(0, 5'd3, 2'b11, 16'hABCD);
    wr(0, 5'd3, 2'b10, 16'h1200);
    rd(1, 5'd3, d, v);
    checks++;
    if (d !== 16'h12CD || v !== 1'b1) begin errors++; $display("FAIL byte_write got %h vld=%b want 12cd vld=1", d, v); end
    tick();
    checks++;
    if (b.vld !== 1'b0 || b.dout !== 16'h12CD) begin errors++; $display("FAIL hold got %h vld=%b want 12cd vld=0", b.dout, b.vld); end
  endtask

  task automatic test_collision();
    logic [15:0] d;
    logic v;
    a.en = 1; a.we = 2'b01; a.addr = 5'd7; a.din = 16'h1111;
    b.en = 1; b.we = 2'b11; b.addr = 5'd7; b.din = 16'h2222;
    tick();
    idle();
    checks++;
    if (col !== 1'b1) begin errors++; $display("FAIL col_pulse got %b want 1", col); end
    tick();
    checks++;
    if (col !== 1'b0) begin errors++; $display("FAIL col_drop got %b want 0", col); end
    rd(0, 5'd7, d, v);
    checks++;
    if (d !== 16'h2211) begin errors++; $display("FAIL col_data got %h want 2211", d); end
    a.en = 1; a.addr = 5'd7; b.en = 1; b.addr = 5'd8;
    b.we = 2'b11; b.din = 16'h0;
    tick();
    idle();
    checks++;
    if (col !== 1'b0) begin errors++; $display("FAIL col_diff_addr got %b want 0", col); end
  endtask

  task automatic test_read_first();
    logic [15:0] d;
    logic v;
    wr(1, 5'd9, 2'b11, 16'h5555);
    a.en = 1; a.addr = 5'd9;
    b.en = 1; b.we = 2'b11; b.addr = 5'd9; b.din = 16'h6666;
    tick();
    idle();
    repeat (OUT_REG) tick();
    checks++;
    if (a.dout !== 16'h5555 || a.vld !== 1'b1) begin errors++; $display("FAIL read_first got %h vld=%b want 5555 vld=1", a.dout, a.vld); end
    rd(0, 5'd9, d, v);
    checks++;
    if (d !== 16'h6666) begin errors++; $display("FAIL read_after got %h want 6666", d); end
  endtask

  task automatic test_clear();
    int n;
    logic [15:0] d;
    logic v;
    wr(0, 5'd4, 2'b11, 16'hBEEF);
    clr = 1;
    tick();
    clr = 0;
    n = 0;
    while (busy && n < 100) begin
      if (n == 20) begin a.en = 1; a.we = 2'b11; a.addr = 5'd5; a.din = 16'h0001; end
      else idle();
      clr = (n == 25);
      n++;
      tick();
      if (n == 21) begin
        checks++;
        if (a.vld !== 1'b0 || col !== 1'b0) begin errors++; $display("FAIL busy_ignore got vlda=%b col=%b want 0 0", a.vld, col); end
      end
    end
    clr = 0;
    idle();
    checks++;
    if (n != 32) begin errors++; $display("FAIL clear_len got %0d want 32", n); end
    rd(0, 5'd4, d, v);
    checks++;
    if (d !== 16'h0) begin errors++; $display("FAIL clear_addr4 got %h want 0000", d); end
    rd(1, 5'd5, d, v);
    checks++;
    if (d !== 16'h0) begin errors++; $display("FAIL clear_addr5 got %h want 0000", d); end
  endtask

  task automatic test_rst_mid_clear();
    int n;
    logic [15:0] d;
    logic v;
    wr(0, 5'd2, 2'b11, 16'h5A5A);
    rd(0, 5'd2, d, v);
    checks++;
    if (d !== 16'h5A5A) begin errors++; $display("FAIL pre_rst got %h want 5a5a", d); end
    wr(1, 5'd6, 2'b11, 16'hC3C3);
    rd(1, 5'd6, d, v);
    clr = 1;
    tick();
    clr = 0;
    repeat (10) tick();
    rst = 1;
    clr = 1;
    a.en = 1; a.we = 2'b11; a.addr = 5'd30; a.din = 16'hFFFF;
    tick();
    rst = 0;
    clr = 0;
    idle();
    checks++;
    if (a.dout !== 16'h0 || b.dout !== 16'h0 || a.vld !== 1'b0 || b.vld !== 1'b0) begin
      errors++;
      $display("FAIL rst_outs got douta=%h doutb=%h vlda=%b vldb=%b want zeros", a.dout, b.dout, a.vld, b.vld);
    end
    n = 0;
    while (busy && n < 100) begin n++; tick(); end
    checks++;
    if (n != 32) begin errors++; $display("FAIL rst_clear_len got %0d want 32", n); end
    rd(0, 5'd30, d, v);
    checks++;
    if (d !== 16'h0) begin errors++; $display("FAIL rst_prio got %h want 0000", d); end
  endtask

  initial begin
    rst = 0;
    clr = 0;
    idle();
    tick();
    test_reset();
    test_byte_write();
    test_collision();
    test_read_first();
    test_clear();
    test_rst_mid_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
